mult_unit: RTL

Sequential HI/LO multiplier that consumes the `start_mult`, `mult_sign` and `out_select` controls produced by the control unit's main decoder. It executes MULT (signed) and MULTU (unsigned) as a radix-2 shift-add over WIDTH cycles and holds the 2×WIDTH product in HI/LO architectural registers. It serves MFHI/MFLO reads through a select mux in the execute stage. It reports `busy` so the hazard unit can stall the pipeline.

---
 rtl/mult_unit_if.sv | 26 ++
 rtl/mult_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mult_unit_if.sv
// Bundles the multiplier's control, operand and result signals.
// The master side drives the request; the slave side is mult_unit.
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_mult;
  logic             mult_sign;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [1:0]       out_select;
  logic [WIDTH-1:0] mult_out;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start_mult, mult_sign, src_a, src_b, out_select,
    input  mult_out, hi, lo, busy, done
  );

  modport slave (
    input  start_mult, mult_sign, src_a, src_b, out_select,
    output mult_out, hi, lo, busy, done
  );
endinterface

// File: rtl/mult_unit.sv
// Sequential radix-2 shift-add HI/LO multiplier (MULT/MULTU) with an
// MFHI/MFLO select mux; signed operands are handled by sign-magnitude.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  mult_unit_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic sign_en);
    logic signed [WIDTH-1:0] neg_v;
    neg_v = -v;
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    return (sign_en && v[WIDTH-1]) ? $unsigned(neg_v) : $unsigned(v);
  endfunction

  function automatic logic [2*WIDTH-1:0] negate2w(input logic [2*WIDTH-1:0] v);
    return (~v) + (2*WIDTH)'(1);
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [WIDTH:0]     sum_c;
  logic [WIDTH-1:0]   addend_c;
  logic               unused_sel;

  assign unused_sel = bus.out_select[1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    addend_c = mplier_q[0] ? mcand_q : '0;
    sum_c    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_c};

    case (state_q)
      IDLE: begin
        if (bus.start_mult) begin
          neg_d    = bus.mult_sign & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
          mcand_d  = magnitude($signed(bus.src_a), bus.mult_sign);
          mplier_d = magnitude($signed(bus.src_b), bus.mult_sign);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        // Carry out of the high half is shifted back in as the new MSB.
        acc_d    = {sum_c, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FIN;
        end
      end
      FIN: begin
        {hi_d, lo_d} = neg_q ? negate2w(acc_q) : acc_q;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Operand registers are reloaded on every accepted start, so they need no reset.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    neg_q    <= neg_d;
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mult_out = bus.out_select[0] ? hi_q : lo_q;

endmodule
